// File: rtl/matrix_operand_loader.sv
// Streams an NxN pair of signed element matrices (N = 2..DIM_MAX) into row-major
// DIM_MAX x DIM_MAX flat operand buses, zero-filled outside the NxN region, with a valid/ack handoff.
module matrix_operand_loader #(
    parameter int ELEM_W  = 8,
    parameter int DIM_MAX = 5
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clear,
    input  logic [2:0]                          mat_size,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [ELEM_W-1:0]                   in_a,
    input  logic [ELEM_W-1:0]                   in_b,
    output logic [DIM_MAX*DIM_MAX*ELEM_W-1:0]   A_flat,
    output logic [DIM_MAX*DIM_MAX*ELEM_W-1:0]   B_flat,
    output logic                                operands_valid,
    input  logic                                operands_ack,
    output logic [4:0]                          elem_count,
    output logic                                size_error
);

    localparam int          BUS_W     = DIM_MAX * DIM_MAX * ELEM_W;
    localparam logic [2:0]  DIM_MAX_L = 3'(DIM_MAX);
    localparam logic [4:0]  ROW_STRIDE = 5'(DIM_MAX);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_FULL = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               valid_q, valid_d;
    logic [2:0]         n_q, n_d;
    logic [2:0]         row_q, row_d;
    logic [2:0]         col_q, col_d;
    logic [4:0]         count_q, count_d;
    logic               size_err_q, size_err_d;
    logic [BUS_W-1:0]   a_q, a_d;
    logic [BUS_W-1:0]   b_q, b_d;

    logic               beat_s;
    logic               first_s;
    logic [2:0]         n_eff_s;
    logic               size_ok_s;
    logic [5:0]         total_s;
    logic [5:0]         count_inc_s;
    logic               last_s;
    logic [4:0]         idx_s;

    // The dimension is only taken from mat_size on the first beat of a load.
    assign beat_s      = in_valid & in_ready_q;
    assign first_s     = (count_q == 5'd0);
    assign n_eff_s     = first_s ? mat_size : n_q;
    assign size_ok_s   = (n_eff_s >= 3'd2) && (n_eff_s <= DIM_MAX_L);
    assign total_s     = {3'b000, n_eff_s} * {3'b000, n_eff_s};
    assign count_inc_s = {1'b0, count_q} + 6'd1;
    assign last_s      = (count_inc_s == total_s);
    assign idx_s       = ({2'b00, row_q} * ROW_STRIDE) + {2'b00, col_q};

    // State register plus registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_LOAD;
            in_ready_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            valid_q    <= valid_d;
        end
    end

    // Next-state logic; clear outranks any beat or ack in the same cycle.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (beat_s && first_s && !size_ok_s) begin
                        state_d = ST_ERR;
                    end else if (beat_s && last_s) begin
                        state_d = ST_FULL;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_FULL: begin
                    if (operands_ack) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                ST_ERR:  state_d = ST_ERR;
                default: state_d = ST_LOAD;
            endcase
        end
    end

    // Handshake outputs follow the state being entered, so they are registered with it.
    always_comb begin
        in_ready_d = 1'b0;
        valid_d    = 1'b0;
        case (state_d)
            ST_LOAD: in_ready_d = 1'b1;
            ST_FULL: valid_d    = 1'b1;
            ST_ERR:  in_ready_d = 1'b0;
            default: in_ready_d = 1'b0;
        endcase
    end

    // Datapath next values: position tracking, bus writes and the sticky size error.
    always_comb begin
        n_d        = n_q;
        row_d      = row_q;
        col_d      = col_q;
        count_d    = count_q;
        size_err_d = size_err_q;
        a_d        = a_q;
        b_d        = b_q;
        if (clear) begin
            row_d      = 3'd0;
            col_d      = 3'd0;
            count_d    = 5'd0;
            size_err_d = 1'b0;
        end else if ((state_q == ST_FULL) && operands_ack) begin
            row_d   = 3'd0;
            col_d   = 3'd0;
            count_d = 5'd0;
        end else if ((state_q == ST_LOAD) && beat_s) begin
            if (first_s && !size_ok_s) begin
                size_err_d = 1'b1;
            end else begin
                n_d = n_eff_s;
                // Wiping on the first beat keeps stale results out of the unused positions.
                if (first_s) begin
                    a_d = '0;
                    b_d = '0;
                end else begin
                    a_d = a_q;
                end
                a_d[int'(idx_s)*ELEM_W +: ELEM_W] = in_a;
                b_d[int'(idx_s)*ELEM_W +: ELEM_W] = in_b;
                if (col_q == (n_eff_s - 3'd1)) begin
                    col_d = 3'd0;
                    row_d = row_q + 3'd1;
                end else begin
                    col_d = col_q + 3'd1;
                end
                count_d = count_inc_s[4:0];
            end
        end else begin
            count_d = count_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q        <= 3'd0;
            row_q      <= 3'd0;
            col_q      <= 3'd0;
            count_q    <= 5'd0;
            size_err_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
        end else begin
            n_q        <= n_d;
            row_q      <= row_d;
            col_q      <= col_d;
            count_q    <= count_d;
            size_err_q <= size_err_d;
            a_q        <= a_d;
            b_q        <= b_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign operands_valid = valid_q;
    assign A_flat         = a_q;
    assign B_flat         = b_q;
    assign elem_count     = count_q;
    assign size_error     = size_err_q;

endmodule

// File: doc/matrix_operand_loader.md
Name: matrix_operand_loader

Overview:
Upstream stage of the ALU element-wise datapath (add/subtract). Accepts an NxN matrix operand pair (N = 2..5) as a stream of signed 8-bit element pairs. Places each pair into the 5x5 row-major flat layout and zero-fills unused positions. Presents A_flat/B_flat with a valid/ack handshake; the ALU stage consumes them combinationally.

Parameters:
ELEM_W, 8, element width in bits (two's complement)
DIM_MAX, 5, maximum matrix dimension; flat buses carry DIM_MAX*DIM_MAX elements

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous reset, active low
clear  in  1  synchronous abort; discards any partial/complete load
mat_size  in  3  matrix dimension N; legal 2..5; sampled on first accepted beat of a load
in_valid  in  1  element pair valid
in_ready  out  1  loader can accept a beat
in_a  in  8  element of A, row-major order
in_b  in  8  element of B, same position as in_a
A_flat  out  200  operand A; element at (r,c) in bits [(r*5+c)*8 +: 8]
B_flat  out  200  operand B; same layout
operands_valid  out  1  A_flat/B_flat complete and stable
operands_ack  in  1  consumer has taken operands; 1-cycle pulse
elem_count  out  5  beats accepted in the current load (0..25)
size_error  out  1  sticky; mat_size illegal at load start

Behaviour:
- Reset (rst_n=0, async): state LOAD; A_flat=0, B_flat=0, operands_valid=0, in_ready=0 during reset and 1 from the first edge after release; elem_count=0; size_error=0; row=col=0.
- States: LOAD, FULL, ERR.
- LOAD: in_ready=1. Beat accepted when in_valid & in_ready.
  - Beat with elem_count==0: latch N=mat_size. If N<2 or N>5: do not store, set size_error, go ERR.
  - Otherwise write in_a/in_b to position row*5+col; col++. When col==N-1: col=0, row++.
  - elem_count increments per accepted beat.
  - On the beat making elem_count==N*N: next cycle operands_valid=1, in_ready=0, state FULL.
- Fill rule: first accepted beat of a load clears all 25 positions of both buses in the same cycle it writes element (0,0). Positions outside the NxN region therefore read 0 once the load completes. Previous results are never mixed in.
- FULL: in_ready=0; buses frozen; operands_valid held high until operands_ack. On ack: next cycle operands_valid=0, elem_count=0, row=col=0, state LOAD. Buses keep their values until the next load's first beat.
- operands_ack outside FULL: ignored.
- ERR: in_ready=0, operands_valid=0. Leave only via clear or reset. clear also drops size_error.
- clear (any state, highest synchronous priority, wins over a same-cycle beat or ack):
  - Next cycle: state LOAD, elem_count=0, row=col=0, operands_valid=0, size_error=0.
  - Buses are not cleared; they clear on the next load's first beat.
- Latency: last beat accepted at edge k -> operands_valid=1 after edge k. Throughput 1 beat/cycle; N*N+1 cycles minimum per load including the ack cycle.
- mat_size changes mid-load: ignored; the latched N governs.
- No arithmetic on data; values pass bit-exact. Signedness is the consumer's concern.

Test Plan:
- N=5, 25 beats a=k, b=2k (k=0..24, 8-bit wrap) -> operands_valid one cycle after beat 25; A_flat[k*8+:8]=k, B_flat[k*8+:8]=(2k)&8'hFF; in_ready=0 until ack.
- N=2 after a full N=5 load, beats (10,3),(-1,5),(127,-128),(0,1) -> positions 0,1,5,6 hold the values; all other 21 positions of both buses are 0; elem_count=4.
- N=3 with in_valid toggling every other cycle -> only handshaked beats counted; position 7 (r1,c2) holds beat 6; operands_valid after 9th accepted beat.
- mat_size=1 on first beat -> size_error=1, in_ready=0, no bus write; clear -> size_error=0, in_ready=1, next N=4 load completes normally.
- clear at elem_count=7 together with in_valid, then new N=2 load -> elem_count restarts at 0; final buses hold only the 4 new elements.
- FULL held 10 cycles with in_valid=1 -> buses unchanged, no beats accepted; ack pulse -> operands_valid=0 next cycle, in_ready=1. Assert rst_n low mid-load -> all outputs 0 immediately (async).
